// File: rtl/packet_buffer_pkg.sv
// Shared types for the packet ingress buffer: header layout, lane FIFO entry
// format and the dispatcher state encoding.
package packet_buffer_pkg;

  localparam int BYTES_PER_BEAT = 8;

  // Header beat, little-endian: packet_length sits in the lowest 16 bits.
  typedef struct packed {
    logic [39:0] reserved;
    logic [7:0]  interface_id;
    logic [15:0] packet_length;
  } packet_header_t;

  // One buffered word plus how many of its low bytes are meaningful (1..8).
  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  count;
  } lane_entry_t;

  typedef enum logic [0:0] {
    ST_HEADER  = 1'b0,
    ST_PAYLOAD = 1'b1
  } dispatch_state_e;

endpackage

// File: rtl/packet_buffer_lane.sv
// One output lane: a word FIFO feeding a byte serializer.
// The FIFO is read combinationally so a word written at edge N is visible
// as the lane's first byte in the very next cycle.
module packet_buffer_lane
  import packet_buffer_pkg::*;
#(
  parameter int LANE_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  lane_entry_t wr_entry,
  output logic        full,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready
);

  localparam int AW = $clog2(LANE_DEPTH);

  lane_entry_t mem [LANE_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [2:0]  idx_reg;
  lane_entry_t head;
  logic        empty;
  logic        handshake;
  logic        pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head       = mem[rd_ptr_reg[AW-1:0]];
  assign byte_valid = !empty;
  assign byte_data  = empty ? 8'h00 : head.data[8*idx_reg +: 8];
  assign handshake  = byte_valid && byte_ready;
  assign pop        = handshake && ({1'b0, idx_reg} == (head.count - 4'd1));

  // Word storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_entry;
    end
  end

  // Pointer and byte-index bookkeeping; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      idx_reg    <= '0;
    end else begin
      if (wr_en && !full) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        idx_reg    <= '0;
      end else if (handshake) begin
        idx_reg <= idx_reg + 3'd1;
      end
    end
  end

endmodule

// File: rtl/packet_buffer.sv
// Packet ingress buffer: dispatches whole packets round-robin onto byte lanes.
// Optional statistics ports are built when PACKET_BUFFER_STATS_EN is defined.
module packet_buffer
  import packet_buffer_pkg::*;
#(
  parameter  int AXI_WIDTH    = 64,
  parameter  int OUTPUT_WIDTH = 8,
  parameter  int LANE_DEPTH   = 16,
  localparam int NUM_LANES    = AXI_WIDTH / OUTPUT_WIDTH
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [AXI_WIDTH-1:0]                   tdata_i,
  input  logic                                   tvalid_i,
  output logic                                   tready_o,
  output logic [NUM_LANES-1:0][OUTPUT_WIDTH-1:0] pkt_tdata_o,
  output logic [NUM_LANES-1:0]                   pkt_tvalid_o,
`ifdef PACKET_BUFFER_STATS_EN
  output logic [NUM_LANES-1:0][31:0]             pkt_count_o,
  output logic                                   drop_free_o,
`endif
  input  logic [NUM_LANES-1:0]                   pkt_tready_i
);

  localparam int LW = $clog2(NUM_LANES);

  if (AXI_WIDTH != 64 || OUTPUT_WIDTH != 8) begin : g_width_error
    $error("packet_buffer: only AXI_WIDTH=64 and OUTPUT_WIDTH=8 are supported");
  end
  if (LANE_DEPTH < 2 || (LANE_DEPTH & (LANE_DEPTH - 1)) != 0) begin : g_depth_error
    $error("packet_buffer: LANE_DEPTH must be a power of two and at least 2");
  end

  dispatch_state_e state_reg, state_next;
  logic [LW-1:0]   lane_ptr_reg, lane_ptr_next, lane_ptr_inc;
  logic [15:0]     remaining_reg, remaining_next;
  logic [NUM_LANES-1:0] full;
  packet_header_t  hdr;
  lane_entry_t     wr_entry;
  logic [3:0]      beat_count;
  logic            accept;

  assign hdr          = tdata_i;
  assign tready_o     = !rst_i && !full[lane_ptr_reg];
  assign accept       = tvalid_i && tready_o;
  assign lane_ptr_inc = (lane_ptr_reg == LW'(NUM_LANES - 1)) ? '0 : lane_ptr_reg + 1'b1;

  // Dispatcher: header beats carry a full 8 bytes, payload beats carry
  // min(remaining, 8); the lane only advances after a packet's last beat.
  always_comb begin
    state_next     = state_reg;
    lane_ptr_next  = lane_ptr_reg;
    remaining_next = remaining_reg;
    beat_count     = 4'(BYTES_PER_BEAT);
    if (state_reg == ST_HEADER) begin
      if (accept) begin
        remaining_next = hdr.packet_length;
        if (hdr.packet_length == 16'd0) begin
          lane_ptr_next = lane_ptr_inc;
        end else begin
          state_next = ST_PAYLOAD;
        end
      end
    end else begin
      beat_count = (remaining_reg >= 16'(BYTES_PER_BEAT)) ? 4'(BYTES_PER_BEAT)
                                                          : remaining_reg[3:0];
      if (accept) begin
        remaining_next = remaining_reg - 16'(beat_count);
        if (remaining_reg <= 16'(BYTES_PER_BEAT)) begin
          lane_ptr_next = lane_ptr_inc;
          state_next    = ST_HEADER;
        end
      end
    end
    wr_entry = '{data: hdr, count: beat_count};
  end

  // Dispatcher state; reset abandons any packet in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_HEADER;
      lane_ptr_reg  <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      lane_ptr_reg  <= lane_ptr_next;
      remaining_reg <= remaining_next;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic lane_sel;
    assign lane_sel = (lane_ptr_reg == LW'(gi));

    packet_buffer_lane #(
      .LANE_DEPTH(LANE_DEPTH)
    ) u_lane (
      .clk        (clk_i),
      .rst        (rst_i),
      .wr_en      (accept && lane_sel),
      .wr_entry   (wr_entry),
      .full       (full[gi]),
      .byte_data  (pkt_tdata_o[gi]),
      .byte_valid (pkt_tvalid_o[gi]),
      .byte_ready (pkt_tready_i[gi])
    );

`ifdef PACKET_BUFFER_STATS_EN
    logic [31:0] pkt_count_reg;
    assign pkt_count_o[gi] = pkt_count_reg;

    // Count packets as their header beat is accepted for this lane.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pkt_count_reg <= '0;
      end else if (accept && lane_sel && state_reg == ST_HEADER) begin
        pkt_count_reg <= pkt_count_reg + 32'd1;
      end
    end
`endif
  end

`ifdef PACKET_BUFFER_STATS_EN
  assign drop_free_o = ~|full;
`endif

endmodule

// File: tb/tb_packet_buffer.sv
// Directed bench for packet_buffer: a packet table (length, interface id,
// payload seed, hand-computed lane) drives the input; each lane's bytes are
// checked against per-lane expected queues built from the table entries.
module tb_packet_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i;
  logic [63:0]     tdata_i;
  logic            tvalid_i;
  logic            tready_o;
  logic [7:0][7:0] pkt_tdata_o;
  logic [7:0]      pkt_tvalid_o;
  logic [7:0]      pkt_tready_i;
`ifdef PACKET_BUFFER_STATS_EN
  logic [7:0][31:0] pkt_count_o;
  logic             drop_free_o;
`endif

  packet_buffer #(.LANE_DEPTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .tdata_i      (tdata_i),
    .tvalid_i     (tvalid_i),
    .tready_o     (tready_o),
    .pkt_tdata_o  (pkt_tdata_o),
    .pkt_tvalid_o (pkt_tvalid_o),
`ifdef PACKET_BUFFER_STATS_EN
    .pkt_count_o  (pkt_count_o),
    .drop_free_o  (drop_free_o),
`endif
    .pkt_tready_i (pkt_tready_i)
  );

  typedef struct {
    int         len;
    logic [7:0] iface;
    logic [7:0] seed;
    int         lane;
  } pkt_vec_t;

  pkt_vec_t   vecs [18];
  logic [7:0] exp_q [8][$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         ready_mode = 0;   // 0: all ready, 1: random, 2: lane 0 stalled
  logic       acc = 1'b0;
  logic       mon_ignore = 1'b1;

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h cycle=%0d", name, got, want, cyc);
    end
  endtask

  // One clock: sample handshakes on the falling edge, drive after the rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    acc = tvalid_i && tready_o && !rst_i;
    for (int k = 0; k < 8; k++) begin
      if (!mon_ignore && !rst_i && pkt_tvalid_o[k] && pkt_tready_i[k]) begin
        total++;
        if (exp_q[k].size() == 0) begin
          bad++;
          $display("FAIL lane%0d_byte got=%02h required=none cycle=%0d", k, pkt_tdata_o[k], cyc);
        end else begin
          e = exp_q[k].pop_front();
          if (pkt_tdata_o[k] !== e) begin
            bad++;
            $display("FAIL lane%0d_byte got=%02h required=%02h cycle=%0d", k, pkt_tdata_o[k], e, cyc);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      1:       pkt_tready_i = 8'($urandom);
      2:       pkt_tready_i = 8'hFE;
      default: pkt_tready_i = 8'hFF;
    endcase
  endtask

  task automatic send_beat(logic [63:0] d);
    int n = 0;
    tdata_i  = d;
    tvalid_i = 1'b1;
    do begin
      tick();
      n++;
    end while (!acc && n < 3000);
    check("beat_accept", 64'(acc), 64'd1);
  endtask

  function automatic logic [63:0] make_hdr(int i);
    return {8'h5A, 8'hC3, 24'(i), vecs[i].iface, 16'(vecs[i].len)};
  endfunction

  function automatic logic [63:0] make_payload(int i, int b);
    logic [63:0] beat;
    int p;
    for (int j = 0; j < 8; j++) begin
      p = 8 * b + j;
      beat[8*j +: 8] = (p < vecs[i].len) ? vecs[i].seed + 8'(p) : 8'hEE;
    end
    return beat;
  endfunction

  // Header bytes first (lowest byte first), then exactly len payload bytes.
  task automatic push_expected(int i);
    logic [63:0] h;
    h = make_hdr(i);
    for (int b = 0; b < 8; b++) exp_q[vecs[i].lane].push_back(h[8*b +: 8]);
    for (int j = 0; j < vecs[i].len; j++) exp_q[vecs[i].lane].push_back(vecs[i].seed + 8'(j));
  endtask

  task automatic send_pkt(int i);
    push_expected(i);
    send_beat(make_hdr(i));
    for (int b = 0; b < (vecs[i].len + 7) / 8; b++) send_beat(make_payload(i, b));
    tvalid_i = 1'b0;
    $display("pkt %0d len=%0d lane=%0d cycle=%0d", i, vecs[i].len, vecs[i].lane, cyc);
  endtask

  task automatic drain(string name);
    int n = 0;
    int left;
    tvalid_i = 1'b0;
    do begin
      tick();
      n++;
      left = 0;
      for (int k = 0; k < 8; k++) left += exp_q[k].size();
    end while (left != 0 && n < 8000);
    check({name, "_left"}, 64'(left), 64'd0);
    repeat (3) tick();
    check({name, "_idle"}, 64'(pkt_tvalid_o), 64'd0);
  endtask

  task automatic do_reset(int cycles);
    mon_ignore = 1'b1;
    rst_i      = 1'b1;
    tvalid_i   = 1'b1;
    tdata_i    = 64'h0000_0000_0000_0010;
    for (int i = 0; i < cycles; i++) begin
      tick();
      check("rst_tready", 64'(tready_o), 64'd0);
      check("rst_tvalid", 64'(pkt_tvalid_o), 64'd0);
      check("rst_tdata", pkt_tdata_o, 64'd0);
    end
    rst_i    = 1'b0;
    tvalid_i = 1'b0;
    for (int k = 0; k < 8; k++) exp_q[k].delete();
    mon_ignore = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    tvalid_i     = 1'b0;
    tdata_i      = '0;
    pkt_tready_i = 8'hFF;

    // {len, interface_id, payload seed, expected lane}
    vecs[0]  = '{5,   8'h01, 8'h10, 0};
    vecs[1]  = '{0,   8'h02, 8'h00, 1};
    vecs[2]  = '{16,  8'h03, 8'h20, 2};
    vecs[3]  = '{8,   8'h04, 8'h30, 3};
    vecs[4]  = '{8,   8'h05, 8'h40, 4};
    vecs[5]  = '{8,   8'h06, 8'h50, 5};
    vecs[6]  = '{8,   8'h07, 8'h60, 6};
    vecs[7]  = '{8,   8'h08, 8'h70, 7};
    vecs[8]  = '{8,   8'h09, 8'h80, 0};
    vecs[9]  = '{8,   8'h0A, 8'h90, 1};
    vecs[10] = '{8,   8'h0B, 8'hA0, 2};
    vecs[11] = '{8,   8'h0C, 8'hB0, 3};
    vecs[12] = '{13,  8'h0D, 8'hC0, 0};
    vecs[13] = '{1,   8'h0E, 8'hD0, 1};
    vecs[14] = '{24,  8'h0F, 8'hE0, 2};
    vecs[15] = '{3,   8'h10, 8'hF0, 3};
    vecs[16] = '{4,   8'h11, 8'h44, 0};
    vecs[17] = '{200, 8'h12, 8'h00, 0};

    // Reset held with tvalid_i high: nothing accepted, nothing emitted.
    do_reset(5);
    tick();
    check("post_rst_tvalid", 64'(pkt_tvalid_o), 64'd0);
    check("post_rst_tready", 64'(tready_o), 64'd1);

    // Single packet, zero-length packet, 16-byte packet, round-robin wrap.
    for (int i = 0; i <= 11; i++) send_pkt(i);
    drain("table_a");

    // Backpressure: lane 0 stalled, 200-byte packet (26 beats) fills 16 words.
    do_reset(2);
    ready_mode = 2;
    tick();
    push_expected(17);
    send_beat(make_hdr(17));
    for (int b = 0; b < 15; b++) send_beat(make_payload(17, b));
    tdata_i  = make_payload(17, 15);
    tvalid_i = 1'b1;
    repeat (20) tick();
    check("bp_stall_acc", 64'(acc), 64'd0);
    check("bp_tready", 64'(tready_o), 64'd0);
    check("bp_tvalid0", 64'(pkt_tvalid_o[0]), 64'd1);
    check("bp_hold_byte", 64'(pkt_tdata_o[0]), 64'hC8);
    ready_mode = 0;
    for (int b = 15; b < 25; b++) send_beat(make_payload(17, b));
    tvalid_i = 1'b0;
    $display("pkt 17 len=200 lane=0 cycle=%0d", cyc);
    drain("backpressure");

    // Random per-lane readiness with a fresh lane pointer.
    do_reset(2);
    ready_mode = 1;
    for (int i = 12; i <= 15; i++) send_pkt(i);
    drain("table_c");
    ready_mode = 0;
    tick();

    // Mid-packet reset: partial 64-byte packet is discarded everywhere.
    mon_ignore = 1'b1;
    tdata_i = {8'h5A, 8'hC3, 24'd77, 8'h99, 16'd64};
    send_beat(tdata_i);
    for (int b = 0; b < 3; b++) send_beat({8{8'(8'h60 + 8'(b))}});
    rst_i    = 1'b1;
    tvalid_i = 1'b0;
    tick();
    check("midrst_tvalid", 64'(pkt_tvalid_o), 64'd0);
    check("midrst_tready", 64'(tready_o), 64'd0);
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 8; k++) exp_q[k].delete();
    mon_ignore = 1'b0;
    send_pkt(16);
    drain("after_midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_buffer.md
Name: packet_buffer

Overview:
- Ingress buffer between a 64-bit AXI4-Stream-style packet source and NUM_LANES byte-wide parser lanes.
- Each incoming packet is a header beat followed by payload beats.
- Whole packets are dispatched round-robin to per-lane word FIFOs, then serialized to bytes on that lane's output.
- Downstream lanes delimit packets using the forwarded header.

Parameters:
- AXI_WIDTH, 64, input beat width in bits; only 64 supported.
- OUTPUT_WIDTH, 8, lane output width in bits; only 8 supported. Elaboration-time $error otherwise.
- LANE_DEPTH, 16, per-lane FIFO depth in 64-bit words; power of two, at least 2.
- NUM_LANES, AXI_WIDTH/OUTPUT_WIDTH (8), number of output lanes; localparam, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- tdata_i  in  AXI_WIDTH  input beat.
- tvalid_i  in  1  input beat valid.
- tready_o  out  1  input beat accepted when tvalid_i && tready_o.
- pkt_tdata_o  out  [NUM_LANES] x OUTPUT_WIDTH  per-lane byte.
- pkt_tvalid_o  out  [NUM_LANES] x 1  per-lane byte valid.
- pkt_tready_i  in  [NUM_LANES] x 1  per-lane byte ready.

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: tready_o=0 while rst_i is high; all pkt_tvalid_o=0; pkt_tdata_o=0.
- Reset side effects: FIFOs emptied, lane pointer=0, FSM=HEADER, byte indices=0.
- Reset mid-packet: the in-flight packet is discarded on every lane.

Header beat (packet_header_t, little-endian):
- [15:0] packet_length: payload bytes, 0..65535.
- [23:16] interface_id.
- [63:24] reserved; forwarded unchanged.

Dispatcher FSM, states HEADER and PAYLOAD:
- tready_o = !rst_i && !full[lane_ptr].
- Accepted beats are written to FIFO[lane_ptr] in the same cycle, with a 4-bit valid-byte count (1..8).
- HEADER, on accept: write the beat with count=8 and latch remaining=packet_length.
  - If packet_length==0: lane_ptr advances (mod NUM_LANES) and the FSM stays in HEADER.
  - Otherwise: go to PAYLOAD.
- PAYLOAD, on accept: count = min(remaining,8); remaining -= count.
  - If remaining<=8 before the subtraction: lane_ptr advances and the FSM goes to HEADER.
- Padding: bytes beyond count in the last payload beat are dropped.
- Backpressure is per beat. A full target lane stalls input; other lanes keep draining.
- No packet ever switches lane mid-packet.

Lane serializer (one per lane):
- pkt_tdata_o[k] = head_word[8*idx +: 8].
- pkt_tvalid_o[k] = FIFO k not empty.
- On handshake: idx++. When idx==count-1, pop the head word and set idx=0.
- Byte order: lowest byte first. The 8 header bytes are emitted, then packet_length payload bytes.
- Latency: a beat accepted at edge N presents its first byte at pkt_tvalid_o in the cycle after edge N.
- Throughput: 1 byte/cycle/lane.
- Simultaneous push and pop on the same FIFO are both honoured; a full FIFO popping this cycle still reports full (no bypass).
- pkt_tdata_o is held stable while pkt_tvalid_o && !pkt_tready_i.

Optional Feature:
- Macro: PACKET_BUFFER_STATS_EN.
- When defined:
  - Adds output pkt_count_o [NUM_LANES] x 32: packets dispatched per lane, incremented on header-beat acceptance, wrapping at 2^32.
  - Adds output drop_free_o 1: asserted while no lane is full.
  - Counters reset to 0.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- packet_buffer_pkg holds:
  - packet_header_t (packed struct: reserved[39:0], interface_id[7:0], packet_length[15:0]);
  - the lane entry struct (data[63:0], count[3:0]);
  - localparam BYTES_PER_BEAT=8;
  - the dispatch FSM enum.
- One sub-module, packet_buffer_lane: FIFO plus serializer, instantiated NUM_LANES times via generate.

Test Plan:
- Reset: hold rst_i for 5 cycles with tvalid_i=1 -> tready_o=0, all pkt_tvalid_o=0; no FIFO writes.
- Single packet, length 5, all pkt_tready_i=1 -> lane 0 emits 8 header bytes then 5 payload bytes (13 bytes, contiguous); the 3 pad bytes are not emitted; the next packet goes to lane 1.
- Zero-length packet followed by a 16-byte packet -> lane 0 emits 8 bytes; lane 1 emits 24 bytes; lane_ptr=2 afterwards.
- Round-robin wrap: 9 packets of length 8 -> lanes 0..7 get one each, lane 0 gets the 9th; byte content matches per lane.
- Backpressure: lane 0 pkt_tready_i=0 with a 200-byte packet -> tready_o drops after LANE_DEPTH=16 words are buffered; on release, all 208 bytes arrive in order with no loss or duplication.
- Mid-packet reset: assert rst_i during PAYLOAD of a 64-byte packet -> the next cycle all pkt_tvalid_o=0; the next header goes to lane 0 and is emitted correctly.
